error_link_tx: RTL and testbench

- Transmit side of the inter-node error link.
- Serialises a node's signed phase-detector error word onto a single wire to the neighbouring node. That node deserialises it and feeds its error_right_i / error_bottom_i.
- A new word is captured on each rising edge of the node's divided generated clock.
- One instance per outgoing neighbour direction (left, above) in the ring-node tile.

---
 rtl/error_link_pkg.sv | 22 ++
 rtl/error_link_tx_sync_edge_det.sv | 26 ++
 rtl/error_link_tx.sv | 187 ++++++++++++++++++
 tb/tb_error_link_tx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/error_link_pkg.sv
// Shared definitions for the inter-node error link (transmitter and receiver).
// Optional parity slot is selected by the ERROR_LINK_PARITY_EN macro.
package error_link_pkg;

   // Line FSM encoding; the receiver decodes frames with the same states
   typedef enum logic [2:0] {
      LINK_IDLE   = 3'd0,
      LINK_START  = 3'd1,
      LINK_DATA   = 3'd2,
      LINK_PARITY = 3'd3,
      LINK_STOP   = 3'd4
   } link_state_e;

   // Line levels
   localparam logic LINE_IDLE_LVL  = 1'b1;
   localparam logic LINE_START_LVL = 1'b0;
   localparam logic LINE_STOP_LVL  = 1'b1;

   // Parity polarity: 0 gives even parity over the data bits
   localparam logic PARITY_POL = 1'b0;

endpackage

// File: rtl/error_link_tx_sync_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// Pulse appears three clk_i edges after the asynchronous input rises.
module sync_edge_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic pulse_o
);

   logic [2:0] sync_q;
   logic       pulse_q;

   // Sync chain plus edge history; pulse is high for one cycle per rising edge
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], d_i};
         pulse_q <= sync_q[1] & ~sync_q[2];
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/error_link_tx.sv
// Error link transmitter: captures the signed phase error on each rising edge
// of the divided generated clock and sends it as start/data/[parity]/stop.
// Parity slot present only when ERROR_LINK_PARITY_EN is defined.
module error_link_tx
   import error_link_pkg::*;
#(
   parameter int unsigned PDET_WIDTH = 5,
   parameter int unsigned BIT_CYCLES = 4,
   parameter int unsigned CNT_WIDTH  = 3
) (
   input  logic                  fpga_clk_i,
   input  logic                  reset_i,
   input  logic                  enable_i,
   input  logic                  gen_div_i,
   input  logic [PDET_WIDTH-1:0] error_i,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  overrun_o
);

   localparam int unsigned IDX_W = (PDET_WIDTH > 1) ? $clog2(PDET_WIDTH) : 1;
   localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(PDET_WIDTH - 1);

   logic                  cap_p;
   logic                  load;
   logic                  bit_end;
   link_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [PDET_WIDTH-1:0] shift_q, shift_d;
   logic [PDET_WIDTH-1:0] hold_q, hold_d;
   logic                  pend_q, pend_d;
   logic                  ovr_q, ovr_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
`ifdef ERROR_LINK_PARITY_EN
   logic                  par_q, par_d;
`endif

   sync_edge_det u_cap_sync (
      .clk_i   (fpga_clk_i),
      .rst_i   (reset_i),
      .d_i     (gen_div_i),
      .pulse_o (cap_p)
   );

   assign bit_end = (cnt_q == BIT_LAST);

   // Line FSM: next state, bit timing, shift register and registered line level
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      load    = 1'b0;
`ifdef ERROR_LINK_PARITY_EN
      par_d   = par_q;
`endif

      if (state_q != LINK_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_WIDTH'(1);
      end

      case (state_q)
         LINK_IDLE: begin
            if (pend_q && enable_i) begin
               load    = 1'b1;
               state_d = LINK_START;
               cnt_d   = '0;
            end
         end
         LINK_START: begin
            if (bit_end) begin
               state_d = LINK_DATA;
               idx_d   = '0;
            end
         end
         LINK_DATA: begin
            if (bit_end) begin
               if (idx_q == IDX_LAST) begin
`ifdef ERROR_LINK_PARITY_EN
                  state_d = LINK_PARITY;
`else
                  state_d = LINK_STOP;
`endif
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
`ifdef ERROR_LINK_PARITY_EN
         LINK_PARITY: begin
            if (bit_end) begin
               state_d = LINK_STOP;
            end
         end
`endif
         LINK_STOP: begin
            if (bit_end) begin
               // A waiting word follows immediately with no idle gap
               if (pend_q && enable_i) begin
                  load    = 1'b1;
                  state_d = LINK_START;
               end else begin
                  state_d = LINK_IDLE;
               end
            end
         end
         default: state_d = LINK_IDLE;
      endcase

      if (load) begin
         shift_d = hold_q;
`ifdef ERROR_LINK_PARITY_EN
         par_d   = (^hold_q) ^ PARITY_POL;
`endif
      end

      tx_d = LINE_IDLE_LVL;
      case (state_d)
         LINK_START:  tx_d = LINE_START_LVL;
         LINK_DATA:   tx_d = shift_d[0];
`ifdef ERROR_LINK_PARITY_EN
         LINK_PARITY: tx_d = par_d;
`endif
         LINK_STOP:   tx_d = LINE_STOP_LVL;
         default:     tx_d = LINE_IDLE_LVL;
      endcase

      busy_d = (state_d != LINK_IDLE);
   end

   // Holding register: capture on the synchronised edge, flag overwrite of an unsent word
   always_comb begin
      hold_d = hold_q;
      pend_d = pend_q;
      ovr_d  = ovr_q;
      if (load) begin
         pend_d = 1'b0;
      end
      if (cap_p && enable_i) begin
         hold_d = error_i;
         pend_d = 1'b1;
         if (pend_q && !load) begin
            ovr_d = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge fpga_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= LINK_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         hold_q  <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
         tx_q    <= LINE_IDLE_LVL;
         busy_q  <= 1'b0;
`ifdef ERROR_LINK_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef ERROR_LINK_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx_o      = tx_q;
   assign busy_o    = busy_q;
   assign overrun_o = ovr_q;

endmodule

// File: tb/tb_error_link_tx.sv
// Directed bench for error_link_tx; frame shape follows ERROR_LINK_PARITY_EN.
module tb_error_link_tx;

   localparam int unsigned PW = 5;
   localparam int unsigned BC = 4;
`ifdef ERROR_LINK_PARITY_EN
   localparam int unsigned NSLOT = PW + 3;
`else
   localparam int unsigned NSLOT = PW + 2;
`endif
   localparam int unsigned NCYC = NSLOT * BC;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic          gdiv = 1'b0;
   logic [PW-1:0] err = '0;
   logic          tx;
   logic          busy;
   logic          ovr;

   int n_cmp = 0;
   int n_fail = 0;

   error_link_tx #(
      .PDET_WIDTH (PW),
      .BIT_CYCLES (BC),
      .CNT_WIDTH  (3)
   ) dut (
      .fpga_clk_i (clk),
      .reset_i    (rst),
      .enable_i   (en),
      .gen_div_i  (gdiv),
      .error_i    (err),
      .tx_o       (tx),
      .busy_o     (busy),
      .overrun_o  (ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line level in frame slot pos: start, data LSB first, [even parity], stop
   function automatic logic exp_bit(input logic [PW-1:0] v, input int pos);
      if (pos == 0) return 1'b0;
      if (pos <= int'(PW)) return v[pos-1];
`ifdef ERROR_LINK_PARITY_EN
      if (pos == int'(PW) + 1) return ^v;
`endif
      return 1'b1;
   endfunction

   // One gen_div_i pulse, 4 cycles high and 4 low, with error_i held throughout
   task automatic gen_edge(input logic [PW-1:0] v);
      err  = v;
      gdiv = 1'b1;
      repeat (4) @(negedge clk);
      gdiv = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_busy(input string tag);
      for (int k = 0; k < 100 && busy !== 1'b1; k++) @(negedge clk);
      chk({tag, "_busy_rise"}, 8'(busy), 8'd1);
   endtask

   // Called on the first START cycle; returns on the cycle after the frame
   task automatic check_frame(input string tag, input logic [PW-1:0] v);
      for (int i = 0; i < int'(NCYC); i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("%s_tx_c%0d", tag, i), 8'(tx), 8'(exp_bit(v, i / int'(BC))));
         chk($sformatf("%s_busy_c%0d", tag, i), 8'(busy), 8'd1);
      end
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tx", 8'(tx), 8'd1);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_ovr", 8'(ovr), 8'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single frame carrying -10
      fork
         gen_edge(5'b10110);
         begin wait_busy("t1"); check_frame("t1", 5'b10110); end
      join
      chk("t1_busy_end", 8'(busy), 8'd0);
      chk("t1_tx_idle", 8'(tx), 8'd1);
      chk("t1_ovr", 8'(ovr), 8'd0);
      repeat (4) @(negedge clk);

      // Second word arrives mid-frame: back-to-back frames, no overrun
      fork
         begin gen_edge(5'd3); gen_edge(5'd7); end
         begin wait_busy("t2"); check_frame("t2a", 5'd3); check_frame("t2b", 5'd7); end
      join
      chk("t2_busy_end", 8'(busy), 8'd0);
      chk("t2_ovr", 8'(ovr), 8'd0);
      repeat (4) @(negedge clk);

      // Three words in one frame: 7 is overwritten by 9, overrun sticks
      fork
         begin gen_edge(5'd3); gen_edge(5'd7); gen_edge(5'd9); end
         begin wait_busy("t3"); check_frame("t3a", 5'd3); check_frame("t3b", 5'd9); end
      join
      chk("t3_busy_end", 8'(busy), 8'd0);
      chk("t3_ovr", 8'(ovr), 8'd1);
      repeat (20) @(negedge clk);
      chk("t3_ovr_sticky", 8'(ovr), 8'd1);
      rst = 1'b1;
      #1;
      chk("t3_ovr_rst", 8'(ovr), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // enable_i low mid-frame: frame completes, the edge during disable is ignored
      fork
         begin gen_edge(5'd13); repeat (2) @(negedge clk); en = 1'b0; gen_edge(5'd21); end
         begin wait_busy("t4"); check_frame("t4a", 5'd13); end
      join
      chk("t4_busy_end", 8'(busy), 8'd0);
      repeat (8) @(negedge clk);
      chk("t4_idle_tx", 8'(tx), 8'd1);
      chk("t4_idle_busy", 8'(busy), 8'd0);
      en = 1'b1;
      repeat (8) @(negedge clk);
      chk("t4_no_capture", 8'(busy), 8'd0);
      fork
         gen_edge(5'd22);
         begin wait_busy("t4b"); check_frame("t4b", 5'd22); end
      join
      chk("t4b_busy_end", 8'(busy), 8'd0);
      repeat (4) @(negedge clk);

      // Async reset during DATA, then a clean frame
      fork
         gen_edge(5'd0);
         begin wait_busy("t5"); repeat (8) @(negedge clk); end
      join
      chk("t5_tx_data", 8'(tx), 8'd0);
      chk("t5_busy_data", 8'(busy), 8'd1);
      rst = 1'b1;
      #1;
      chk("t5_tx_rst", 8'(tx), 8'd1);
      chk("t5_busy_rst", 8'(busy), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      fork
         gen_edge(5'b11001);
         begin wait_busy("t5b"); check_frame("t5b", 5'b11001); end
      join
      chk("t5b_busy_end", 8'(busy), 8'd0);
      repeat (4) @(negedge clk);

      // Word 1: single one right after start
      fork
         gen_edge(5'b00001);
         begin wait_busy("t6"); check_frame("t6", 5'b00001); end
      join
      chk("t6_busy_end", 8'(busy), 8'd0);
      chk("t6_ovr", 8'(ovr), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
